// File: rtl/sram_grid_pkg.sv
// Shared state encoding and grid pin constants for the SRAM grid initiator.
package sram_grid_pkg;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_WORDS  = 8;

    localparam logic GRID_RW_WRITE = 1'b1;
    localparam logic GRID_RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD,
        ST_RPULSE,
        ST_RCAP,
        ST_RESP
    } state_t;
endpackage

// File: rtl/sram_grid_ctrl_if.sv
// Request/response bus and grid pins; master is the controller that initiates grid access,
// slave is the environment (requester plus grid macro).
interface sram_grid_ctrl_if import sram_grid_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_WORDS
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              grid_rw;
    logic [WORDS-1:0]  grid_wordline;
    logic [DATA_W-1:0] grid_wdata;
    logic [DATA_W-1:0] grid_bitlines;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, grid_bitlines,
        output req_ready, resp_valid, resp_rdata, resp_err, grid_rw, grid_wordline, grid_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, grid_bitlines,
        input  req_ready, resp_valid, resp_rdata, resp_err, grid_rw, grid_wordline, grid_wdata
    );
endinterface

// File: rtl/grid_wordline_dec.sv
// Binary word address to one-hot wordline vector; addresses past WORDS decode to all-zero.
module grid_wordline_dec import sram_grid_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [WORDS-1:0]  o_onehot
);
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < WORDS; i++) begin
            o_onehot[i] = i_en && (i_addr == ADDR_W'(i));
        end
    end
endmodule

// File: rtl/sram_grid_ctrl.sv
// Sequences the async SRAM grid pins: IDLE -> WSETUP/WPULSE/WHOLD (write) or RPULSE/RCAP (read)
// -> RESP. All outputs are registered; one request outstanding at a time.
module sram_grid_ctrl import sram_grid_pkg::*; #(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int WORDS        = DEF_WORDS,
    parameter int WRITE_CYCLES = 2,
    parameter int READ_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    sram_grid_ctrl_if.master bus
);
    localparam int MAX_CYC = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              r_grid_rw;
    logic [WORDS-1:0]  r_grid_wordline;
    logic [DATA_W-1:0] r_grid_wdata;

    logic              w_accept;
    logic              w_addr_oob;
    logic [ADDR_W-1:0] w_dec_addr;
    logic [WORDS-1:0]  w_onehot;

    assign w_accept   = bus.req_valid && r_req_ready;
    assign w_addr_oob = ({1'b0, bus.req_addr} >= (ADDR_W+1)'(WORDS));
    // Reads raise the wordline on the accept edge, before r_addr has been loaded.
    assign w_dec_addr = (r_state == ST_IDLE) ? bus.req_addr : r_addr;

    grid_wordline_dec #(.ADDR_W(ADDR_W), .WORDS(WORDS)) u_dec (
        .i_addr   (w_dec_addr),
        .i_en     (1'b1),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_addr          <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_err      <= 1'b0;
            r_grid_rw       <= GRID_RW_READ;
            r_grid_wordline <= '0;
            r_grid_wdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_addr       <= bus.req_addr;
                        r_cnt        <= '0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                        if (w_addr_oob) begin
                            r_state    <= ST_RESP;
                            r_resp_err <= 1'b1;
                        end else if (bus.req_we) begin
                            r_state      <= ST_WSETUP;
                            r_grid_rw    <= GRID_RW_WRITE;
                            r_grid_wdata <= bus.req_wdata;
                        end else begin
                            r_state         <= ST_RPULSE;
                            r_grid_rw       <= GRID_RW_READ;
                            r_grid_wordline <= w_onehot;
                        end
                    end
                end
                ST_WSETUP: begin
                    r_state         <= ST_WPULSE;
                    r_cnt           <= '0;
                    r_grid_wordline <= w_onehot;
                end
                ST_WPULSE: begin
                    if (r_cnt == WR_LAST) begin
                        r_state         <= ST_WHOLD;
                        r_cnt           <= '0;
                        r_grid_wordline <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WHOLD: begin
                    r_state      <= ST_RESP;
                    r_cnt        <= '0;
                    r_grid_rw    <= GRID_RW_READ;
                    r_resp_valid <= 1'b1;
                end
                ST_RPULSE: begin
                    if (r_cnt == RD_LAST) begin
                        r_state <= ST_RCAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RCAP: begin
                    r_state         <= ST_RESP;
                    r_cnt           <= '0;
                    r_resp_rdata    <= bus.grid_bitlines;
                    r_grid_wordline <= '0;
                    r_resp_valid    <= 1'b1;
                end
                ST_RESP: begin
                    // Error requests arrive with valid low so the response lands one cycle after accept.
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                    end else if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= '0;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.resp_err      = r_resp_err;
    assign bus.grid_rw       = r_grid_rw;
    assign bus.grid_wordline = r_grid_wordline;
    assign bus.grid_wdata    = r_grid_wdata;
endmodule
